tankb_rom_loader: RTL and testbench

Download-path stage between the `hps_io` ioctl interface and the `Tankb_fpga` game core. It accepts the ROM byte stream for one ioctl index and re-times it onto the core's `dn_addr`/`dn_data`/`dn_wr` port. It throttles the HPS with `ioctl_wait`, counts and checksums the accepted bytes, and holds the core in reset until a complete image has been delivered.

---
 rtl/tankb_rom_loader.sv | 129 ++++++++++++
 tb/tb_tankb_rom_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tankb_rom_loader.sv
// ROM download stage between hps_io and the Tankb core: re-times accepted ioctl bytes
// onto dn_addr/dn_data/dn_wr, stalls the HPS after each byte and gates core reset.
//
// state | meaning
// IDLE  | no valid image, core held in reset, waiting for a rising edge of sel
// LOAD  | download active, ready to accept a byte
// HOLD  | byte taken, ioctl_wait asserted for WR_HOLD clocks
// DONE  | complete image delivered, core released from reset
module tankb_rom_loader #(
    parameter int ROM_INDEX = 0,
    parameter int ROM_BYTES = 16384,
    parameter int WR_HOLD   = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [13:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        rom_ready,
    output logic        load_error,
    output logic [14:0] bytes_loaded,
    output logic [15:0] checksum
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_HOLD, ST_DONE} state_t;

    localparam logic [7:0]  SEL_IDX  = 8'(ROM_INDEX);
    localparam logic [24:0] ADDR_LIM = 25'(ROM_BYTES);
    localparam logic [14:0] IMG_LEN  = 15'(ROM_BYTES);
    localparam logic [14:0] CNT_MAX  = 15'd16384;
    localparam logic [2:0]  HOLD_LD  = 3'(WR_HOLD - 1);

    state_t      state, state_nxt;
    logic        sel, sel_q, sel_rise, sel_fall;
    logic [2:0]  hold_cnt;
    logic        overrun;
    logic        start, accept, reject, finish_err;

    assign sel      = ioctl_download & (ioctl_index == SEL_IDX);
    assign sel_rise = sel & ~sel_q;
    assign sel_fall = ~sel & sel_q;

    assign ioctl_wait = (state == ST_HOLD);
    assign rom_ready  = (state == ST_DONE);
    assign core_reset = (state != ST_DONE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        finish_err = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (sel_rise) begin
                    state_nxt = ST_LOAD;
                    start     = 1'b1;
                end
            end
            ST_LOAD, ST_HOLD: begin
                // end of window wins over any pending byte or hold count
                if (sel_fall) begin
                    if (bytes_loaded == IMG_LEN && !overrun) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt  = ST_IDLE;
                        finish_err = 1'b1;
                    end
                end else if (state == ST_LOAD) begin
                    if (ioctl_wr) begin
                        state_nxt = ST_HOLD;
                        if (ioctl_addr < ADDR_LIM) accept = 1'b1;
                        else                       reject = 1'b1;
                    end
                end else if (hold_cnt == 3'd0) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // sel_q resets high so a sel still asserted across reset is not seen as a new edge
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sel_q        <= 1'b1;
            hold_cnt     <= 3'd0;
            overrun      <= 1'b0;
            dn_addr      <= 14'd0;
            dn_data      <= 8'd0;
            dn_wr        <= 1'b0;
            load_error   <= 1'b0;
            bytes_loaded <= 15'd0;
            checksum     <= 16'd0;
        end else begin
            sel_q <= sel;
            dn_wr <= accept;
            if (start) begin
                bytes_loaded <= 15'd0;
                checksum     <= 16'd0;
                load_error   <= 1'b0;
                overrun      <= 1'b0;
            end
            if (accept) begin
                dn_addr  <= ioctl_addr[13:0];
                dn_data  <= ioctl_dout;
                checksum <= checksum + {8'h00, ioctl_dout};
                if (bytes_loaded != CNT_MAX) bytes_loaded <= bytes_loaded + 15'd1;
            end
            if (reject)     overrun    <= 1'b1;
            if (finish_err) load_error <= 1'b1;
            if (accept || reject)                         hold_cnt <= HOLD_LD;
            else if (state == ST_HOLD && hold_cnt != 3'd0) hold_cnt <= hold_cnt - 3'd1;
        end
    end

endmodule

// File: tb/tb_tankb_rom_loader.sv
// Bench for tankb_rom_loader: a 16-byte and a 16384-byte loader on shared ioctl inputs,
// scoreboard on dn_wr, reference model of count/checksum/outcome kept per download.
`timescale 1ns/1ps
module tb_tankb_rom_loader;

    localparam int SM_BYTES = 16;
    localparam int BG_BYTES = 16384;
    localparam int HOLD     = 2;
    localparam int SM_IDX   = 0;
    localparam int BG_IDX   = 2;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;

    logic        sm_wait, sm_dn_wr, sm_core_reset, sm_ready, sm_err;
    logic [13:0] sm_dn_addr;
    logic [7:0]  sm_dn_data;
    logic [14:0] sm_bl;
    logic [15:0] sm_cs;
    logic        bg_wait, bg_dn_wr, bg_core_reset, bg_ready, bg_err;
    logic [13:0] bg_dn_addr;
    logic [7:0]  bg_dn_data;
    logic [14:0] bg_bl;
    logic [15:0] bg_cs;

    tankb_rom_loader #(.ROM_INDEX(SM_IDX), .ROM_BYTES(SM_BYTES), .WR_HOLD(HOLD)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(sm_wait), .dn_addr(sm_dn_addr),
        .dn_data(sm_dn_data), .dn_wr(sm_dn_wr), .core_reset(sm_core_reset),
        .rom_ready(sm_ready), .load_error(sm_err), .bytes_loaded(sm_bl), .checksum(sm_cs)
    );

    tankb_rom_loader #(.ROM_INDEX(BG_IDX), .ROM_BYTES(BG_BYTES), .WR_HOLD(HOLD)) dut_big (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(bg_wait), .dn_addr(bg_dn_addr),
        .dn_data(bg_dn_data), .dn_wr(bg_dn_wr), .core_reset(bg_core_reset),
        .rom_ready(bg_ready), .load_error(bg_err), .bytes_loaded(bg_bl), .checksum(bg_cs)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc++;

    typedef struct {
        logic [13:0] a;
        logic [7:0]  d;
        int          c;
    } exp_t;

    exp_t q_sm[$];
    exp_t q_bg[$];
    exp_t e_sm, e_bg;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model of the download in progress
    int          m_count;
    logic [15:0] m_sum;
    bit          m_over;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic bad(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic wait_of(input bit tgt);
        return tgt ? bg_wait : sm_wait;
    endfunction

    always @(negedge clk_sys) begin
        if (sm_dn_wr) begin
            if (q_sm.size() == 0) bad("sm_unexpected_dn_wr");
            else begin
                e_sm = q_sm.pop_front();
                chk("sm_dn_addr", 32'(sm_dn_addr), 32'(e_sm.a));
                chk("sm_dn_data", 32'(sm_dn_data), 32'(e_sm.d));
                chk("sm_dn_wr_cycle", 32'(cyc), 32'(e_sm.c));
            end
        end
        if (bg_dn_wr) begin
            if (q_bg.size() == 0) bad("bg_unexpected_dn_wr");
            else begin
                e_bg = q_bg.pop_front();
                chk("bg_dn_addr", 32'(bg_dn_addr), 32'(e_bg.a));
                chk("bg_dn_data", 32'(bg_dn_data), 32'(e_bg.d));
                chk("bg_dn_wr_cycle", 32'(cyc), 32'(e_bg.c));
            end
        end
    end

    task automatic start_dl(input bit tgt, input int idx);
        ioctl_download = 1'b1;
        ioctl_index    = 8'(idx);
        m_count = 0;
        m_sum   = 16'd0;
        m_over  = 1'b0;
        tick();
        chk("start_core_reset", 32'(tgt ? bg_core_reset : sm_core_reset), 32'd1);
        chk("start_rom_ready", 32'(tgt ? bg_ready : sm_ready), 32'd0);
    endtask

    task automatic send(input bit tgt, input logic [24:0] a, input logic [7:0] d, input int gap);
        int n;
        int lim;
        lim = tgt ? BG_BYTES : SM_BYTES;
        repeat (gap) tick();
        n = 0;
        while (wait_of(tgt) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) bad("send_wait_timeout");
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (int'(a) < lim) begin
            if (m_count < 16384) m_count++;
            m_sum = m_sum + 16'(d);
            if (tgt) q_bg.push_back('{a: a[13:0], d: d, c: cyc + 1});
            else     q_sm.push_back('{a: a[13:0], d: d, c: cyc + 1});
        end else begin
            m_over = 1'b1;
        end
        tick();
        ioctl_wr = 1'b0;
        chk("wait_first", 32'(wait_of(tgt)), 32'd1);
        chk("count_n1", 32'(tgt ? bg_bl : sm_bl), 32'(m_count));
        chk("sum_n1", 32'(tgt ? bg_cs : sm_cs), 32'(m_sum));
        for (int k = 1; k < HOLD; k++) begin
            tick();
            chk("wait_hold", 32'(wait_of(tgt)), 32'd1);
        end
        tick();
        chk("wait_release", 32'(wait_of(tgt)), 32'd0);
    endtask

    task automatic raw_wr(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        chk("raw_no_wait", 32'(sm_wait), 32'd0);
        tick();
        tick();
    endtask

    task automatic end_dl(input bit tgt, input bit same_wr);
        bit ok;
        int lim;
        lim = tgt ? BG_BYTES : SM_BYTES;
        ioctl_download = 1'b0;
        if (same_wr) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(m_count);
            ioctl_dout = 8'h5A;
        end
        tick();
        ioctl_wr = 1'b0;
        ok = (m_count == lim) && !m_over;
        chk("end_rom_ready", 32'(tgt ? bg_ready : sm_ready), 32'(ok));
        chk("end_load_error", 32'(tgt ? bg_err : sm_err), 32'(!ok));
        chk("end_core_reset", 32'(tgt ? bg_core_reset : sm_core_reset), 32'(!ok));
        chk("end_bytes", 32'(tgt ? bg_bl : sm_bl), 32'(m_count));
        chk("end_checksum", 32'(tgt ? bg_cs : sm_cs), 32'(m_sum));
    endtask

    task automatic check_reset_vals();
        chk("rst_wait", 32'(sm_wait), 32'd0);
        chk("rst_dn_addr", 32'(sm_dn_addr), 32'd0);
        chk("rst_dn_data", 32'(sm_dn_data), 32'd0);
        chk("rst_dn_wr", 32'(sm_dn_wr), 32'd0);
        chk("rst_core_reset", 32'(sm_core_reset), 32'd1);
        chk("rst_rom_ready", 32'(sm_ready), 32'd0);
        chk("rst_load_error", 32'(sm_err), 32'd0);
        chk("rst_bytes", 32'(sm_bl), 32'd0);
        chk("rst_checksum", 32'(sm_cs), 32'd0);
    endtask

    initial begin
        #6_000_000;
        bad("watchdog");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int perm[16];
        int j, tmp, cnt;
        #1;
        check_reset_vals();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // in-order full image
        start_dl(0, SM_IDX);
        for (int i = 0; i < 16; i++) send(0, 25'(i), 8'(i + 1), $urandom_range(0, 2));
        end_dl(0, 0);
        chk("full_checksum", 32'(sm_cs), 32'h0088);
        chk("full_bytes", 32'(sm_bl), 32'd16);

        // foreign index leaves the loaded image alone
        ioctl_download = 1'b1;
        ioctl_index    = 8'd1;
        tick();
        for (int i = 0; i < 4; i++) raw_wr(25'(i), 8'($urandom_range(0, 255)));
        ioctl_download = 1'b0;
        tick();
        chk("foreign_ready", 32'(sm_ready), 32'd1);
        chk("foreign_checksum", 32'(sm_cs), 32'h0088);
        chk("foreign_core_reset", 32'(sm_core_reset), 32'd0);

        // short image; last byte lands on the falling edge and is dropped
        start_dl(0, SM_IDX);
        for (int i = 0; i < 15; i++) send(0, 25'(i), 8'($urandom_range(0, 255)), 0);
        end_dl(0, 1);
        chk("short_bytes", 32'(sm_bl), 32'd15);

        // overrun past the image end
        start_dl(0, SM_IDX);
        for (int i = 0; i < 16; i++) send(0, 25'(i), 8'($urandom_range(0, 255)), 0);
        send(0, 25'd16, 8'hAB, 0);
        end_dl(0, 0);
        chk("overrun_error", 32'(sm_err), 32'd1);

        // shuffled addresses, random data
        for (int i = 0; i < 16; i++) perm[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        start_dl(0, SM_IDX);
        for (int i = 0; i < 16; i++) send(0, 25'(perm[i]), 8'($urandom_range(0, 255)), $urandom_range(0, 3));
        end_dl(0, 0);
        chk("shuffle_ready", 32'(sm_ready), 32'd1);

        // random addresses with possible duplicates and out-of-range bytes
        for (int r = 0; r < 4; r++) begin
            start_dl(0, SM_IDX);
            cnt = int'($urandom_range(14, 18));
            for (int i = 0; i < cnt; i++) send(0, 25'($urandom_range(0, 17)), 8'($urandom_range(0, 255)), $urandom_range(0, 2));
            end_dl(0, 0);
        end

        // asynchronous reset mid-download
        start_dl(0, SM_IDX);
        for (int i = 0; i < 8; i++) send(0, 25'(i), 8'(i + 1), 0);
        #2 reset = 1'b1;
        #1;
        check_reset_vals();
        tick();
        reset = 1'b0;
        tick();
        tick();
        raw_wr(25'd0, 8'h77);
        chk("post_rst_bytes", 32'(sm_bl), 32'd0);
        chk("post_rst_core_reset", 32'(sm_core_reset), 32'd1);
        ioctl_download = 1'b0;
        tick();
        chk("post_rst_error", 32'(sm_err), 32'd0);
        chk("post_rst_ready", 32'(sm_ready), 32'd0);
        start_dl(0, SM_IDX);
        for (int i = 0; i < 16; i++) send(0, 25'(i), 8'($urandom_range(0, 255)), 0);
        end_dl(0, 0);
        chk("post_rst_done", 32'(sm_ready), 32'd1);

        // full-size image of 0xFF: checksum wraps
        start_dl(1, BG_IDX);
        for (int i = 0; i < BG_BYTES; i++) send(1, 25'(i), 8'hFF, 0);
        end_dl(1, 0);
        chk("wrap_checksum", 32'(bg_cs), 32'hC000);
        chk("wrap_bytes", 32'(bg_bl), 32'd16384);
        chk("wrap_ready", 32'(bg_ready), 32'd1);
        chk("wrap_sm_untouched", 32'(sm_ready), 32'd1);

        repeat (3) tick();
        chk("sm_queue_drained", 32'(q_sm.size()), 32'd0);
        chk("bg_queue_drained", 32'(q_bg.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
